// File: rtl/cpu_load_ctrl.sv
// Host-side loader/runner for a small CPU: streams instruction and data words into
// the CPU memories, then releases the CPU from reset for a bounded run.
module cpu_load_ctrl #(
   parameter int ADDR_W  = 5,
   parameter int MAX_RUN = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [7:0]        cmd_data,
   input  logic              cpu_halt,
   output logic              cpu_reset,
   output logic              cpu_load,
   output logic [ADDR_W-1:0] cpu_load_address,
   output logic              cpu_is_instruction,
   output logic [7:0]        cpu_data,
   output logic [1:0]        state,
   output logic              timeout,
   output logic              err,
   output logic [ADDR_W:0]   instr_count
);

   localparam int CNT_W = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_RUN > 0) ? MAX_RUN - 1 : 0);
   localparam logic [ADDR_W:0] ICOUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_HALTED = 2'd3} state_t;
   typedef enum logic [1:0] {OP_WR_INSTR = 2'd0, OP_WR_DATA = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3} op_t;

   op_t op;
   assign op = op_t'(cmd_op);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] iptr_q, iptr_d, dptr_q, dptr_d, addr_q, addr_d;
   logic [ADDR_W-1:0] ip, dp;
   logic [ADDR_W:0]   icount_q, icount_d, ic;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic              timeout_q, timeout_d, err_q, err_d;
   logic              cpu_reset_q, cpu_reset_d, load_q, load_d, is_instr_q, is_instr_d;
   logic [7:0]        data_q, data_d;
   logic              ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         iptr_q      <= '0;
         dptr_q      <= '0;
         addr_q      <= '0;
         icount_q    <= '0;
         run_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         err_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         load_q      <= 1'b0;
         is_instr_q  <= 1'b0;
         data_q      <= '0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         iptr_q      <= iptr_d;
         dptr_q      <= dptr_d;
         addr_q      <= addr_d;
         icount_q    <= icount_d;
         run_cnt_q   <= run_cnt_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         cpu_reset_q <= cpu_reset_d;
         load_q      <= load_d;
         is_instr_q  <= is_instr_d;
         data_q      <= data_d;
         ready_q     <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      iptr_d      = iptr_q;
      dptr_d      = dptr_q;
      addr_d      = addr_q;
      icount_d    = icount_q;
      run_cnt_d   = run_cnt_q;
      timeout_d   = timeout_q;
      err_d       = err_q;
      cpu_reset_d = cpu_reset_q;
      load_d      = 1'b0;
      is_instr_d  = is_instr_q;
      data_d      = data_q;
      ip          = iptr_q;
      dp          = dptr_q;
      ic          = icount_q;

      if (state_q == S_RUN) begin
         run_cnt_d = run_cnt_q + CNT_W'(1);
         if (cmd_valid && (op == OP_WR_INSTR || op == OP_WR_DATA)) begin
            err_d = 1'b1;
         end
         // Halt has priority so a run that ends cleanly never reports a timeout
         if (cpu_halt || (cmd_valid && op == OP_STOP)) begin
            state_d     = S_HALTED;
            timeout_d   = 1'b0;
            cpu_reset_d = 1'b1;
         end else if (MAX_RUN != 0 && run_cnt_q == LAST_CNT) begin
            state_d     = S_HALTED;
            timeout_d   = 1'b1;
            cpu_reset_d = 1'b1;
         end
      end else if (cmd_valid) begin
         case (op)
            OP_WR_INSTR, OP_WR_DATA: begin
               // A new load after a run starts a fresh program image
               if (state_q == S_HALTED) begin
                  ip        = '0;
                  dp        = '0;
                  ic        = '0;
                  timeout_d = 1'b0;
                  err_d     = 1'b0;
               end
               state_d    = S_LOAD;
               load_d     = 1'b1;
               data_d     = cmd_data;
               is_instr_d = (op == OP_WR_INSTR);
               iptr_d     = ip;
               dptr_d     = dp;
               icount_d   = ic;
               if (op == OP_WR_INSTR) begin
                  addr_d   = ip;
                  iptr_d   = ip + ADDR_W'(1);
                  icount_d = (ic == ICOUNT_MAX) ? ic : ic + (ADDR_W + 1)'(1);
               end else begin
                  addr_d = dp;
                  dptr_d = dp + ADDR_W'(1);
               end
            end
            OP_RUN: begin
               state_d     = S_RUN;
               cpu_reset_d = 1'b0;
               run_cnt_d   = '0;
               timeout_d   = 1'b0;
            end
            default: begin
               if (state_q == S_LOAD) begin
                  state_d  = S_IDLE;
                  iptr_d   = '0;
                  dptr_d   = '0;
                  icount_d = '0;
               end
            end
         endcase
      end
   end

   assign cmd_ready          = ready_q;
   assign cpu_reset          = cpu_reset_q;
   assign cpu_load           = load_q;
   assign cpu_load_address   = addr_q;
   assign cpu_is_instruction = is_instr_q;
   assign cpu_data           = data_q;
   assign state              = state_q;
   assign timeout            = timeout_q;
   assign err                = err_q;
   assign instr_count        = icount_q;

endmodule

// File: tb/tb_cpu_load_ctrl.sv
// Directed bench for cpu_load_ctrl: a default-budget instance (a) and an
// eight-cycle-budget instance (b) share one command stream.
module tb_cpu_load_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       cpu_halt = 1'b0;

   logic       ready_a, rst_a, load_a, instr_a, to_a, err_a;
   logic [4:0] addr_a;
   logic [7:0] data_a;
   logic [1:0] state_a;
   logic [5:0] ic_a;
   logic       ready_b, rst_b, load_b, instr_b, to_b, err_b;
   logic [4:0] addr_b;
   logic [7:0] data_b;
   logic [1:0] state_b;
   logic [5:0] ic_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_load_ctrl #(.ADDR_W(5)) dut_a (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cpu_halt(cpu_halt), .cpu_reset(rst_a),
      .cpu_load(load_a), .cpu_load_address(addr_a), .cpu_is_instruction(instr_a),
      .cpu_data(data_a), .state(state_a), .timeout(to_a), .err(err_a), .instr_count(ic_a));

   cpu_load_ctrl #(.ADDR_W(5), .MAX_RUN(8)) dut_b (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cpu_halt(cpu_halt), .cpu_reset(rst_b),
      .cpu_load(load_b), .cpu_load_address(addr_b), .cpu_is_instruction(instr_b),
      .cpu_data(data_b), .state(state_b), .timeout(to_b), .err(err_b), .instr_count(ic_b));

   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [7:0] data;
      logic       halt;
      logic       e_load;
      logic [4:0] e_addr;
      logic       e_instr;
      logic [7:0] e_data;
      logic [1:0] e_state;
      logic       e_rst;
      logic [5:0] e_ic;
      logic       e_to;
      logic       e_err;
   } vec_t;

   vec_t vecs[14];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one command for one clock and leave time just after the edge for sampling
   task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [7:0] data,
                                input logic halt);
      @(negedge clk);
      cmd_valid = valid;
      cmd_op    = op;
      cmd_data  = data;
      cpu_halt  = halt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".state"}, state_a, 0);
      checkOutput({tag, ".cpu_reset"}, rst_a, 1);
      checkOutput({tag, ".load"}, load_a, 0);
      checkOutput({tag, ".addr"}, addr_a, 0);
      checkOutput({tag, ".instr"}, instr_a, 0);
      checkOutput({tag, ".data"}, data_a, 0);
      checkOutput({tag, ".timeout"}, to_a, 0);
      checkOutput({tag, ".err"}, err_a, 0);
      checkOutput({tag, ".icount"}, ic_a, 0);
      checkOutput({tag, ".state_b"}, state_b, 0);
      checkOutput({tag, ".load_b"}, load_b, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int low_a, low_b;

      //                 vld op   data   hlt  load addr ins data   st  rst ic  to err
      vecs[0]  = '{1'b1, 2'd0, 8'hA1, 1'b0, 1'b1, 5'd0, 1'b1, 8'hA1, 2'd1, 1'b1, 6'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 2'd0, 8'hB2, 1'b0, 1'b1, 5'd1, 1'b1, 8'hB2, 2'd1, 1'b1, 6'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 2'd1, 8'h07, 1'b0, 1'b1, 5'd0, 1'b0, 8'h07, 2'd1, 1'b1, 6'd2, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h07, 2'd1, 1'b1, 6'd2, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h07, 2'd0, 1'b1, 6'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 2'd1, 8'h11, 1'b0, 1'b1, 5'd0, 1'b0, 8'h11, 2'd1, 1'b1, 6'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 2'd1, 8'h22, 1'b0, 1'b1, 5'd1, 1'b0, 8'h22, 2'd1, 1'b1, 6'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'h22, 2'd2, 1'b0, 6'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 2'd0, 8'h33, 1'b0, 1'b0, 5'd1, 1'b0, 8'h22, 2'd2, 1'b0, 6'd0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'h22, 2'd2, 1'b0, 6'd0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 2'd3, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 8'h22, 2'd3, 1'b1, 6'd0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'h22, 2'd3, 1'b1, 6'd0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 2'd0, 8'h44, 1'b0, 1'b1, 5'd0, 1'b1, 8'h44, 2'd1, 1'b1, 6'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 2'd1, 8'h55, 1'b0, 1'b1, 5'd0, 1'b0, 8'h55, 2'd1, 1'b1, 6'd1, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      checkOutput("reset.ready", ready_a, 1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].data, vecs[i].halt);
         checkOutput($sformatf("v%0d.load", i), load_a, vecs[i].e_load);
         checkOutput($sformatf("v%0d.addr", i), addr_a, vecs[i].e_addr);
         checkOutput($sformatf("v%0d.instr", i), instr_a, vecs[i].e_instr);
         checkOutput($sformatf("v%0d.data", i), data_a, vecs[i].e_data);
         checkOutput($sformatf("v%0d.state", i), state_a, vecs[i].e_state);
         checkOutput($sformatf("v%0d.cpu_reset", i), rst_a, vecs[i].e_rst);
         checkOutput($sformatf("v%0d.icount", i), ic_a, vecs[i].e_ic);
         checkOutput($sformatf("v%0d.timeout", i), to_a, vecs[i].e_to);
         checkOutput($sformatf("v%0d.err", i), err_a, vecs[i].e_err);
         checkOutput($sformatf("v%0d.ready", i), ready_a, 1);
      end

      // Pointer wrap and instruction-count saturation over 33 writes
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 33; i++) begin
         applyStimulus(1'b1, 2'd0, 8'(i), 1'b0);
         checkOutput($sformatf("wrap%0d.load", i), load_a, 1);
         checkOutput($sformatf("wrap%0d.addr", i), addr_a, i % 32);
         checkOutput($sformatf("wrap%0d.icount", i), ic_a, (i + 1 > 32) ? 32 : i + 1);
      end

      // Run: a halts via cpu_halt in its 10th run cycle, b exhausts its 8-cycle budget
      low_a = 0;
      low_b = 0;
      applyStimulus(1'b1, 2'd2, 8'h00, 1'b0);
      if (rst_a === 1'b0) low_a++;
      if (rst_b === 1'b0) low_b++;
      for (int k = 1; k <= 15; k++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, k == 10);
         if (rst_a === 1'b0) low_a++;
         if (rst_b === 1'b0) low_b++;
      end
      checkOutput("halt.low_cycles_a", low_a, 10);
      checkOutput("halt.state_a", state_a, 3);
      checkOutput("halt.timeout_a", to_a, 0);
      checkOutput("budget.low_cycles_b", low_b, 8);
      checkOutput("budget.state_b", state_b, 3);
      checkOutput("budget.timeout_b", to_b, 1);

      applyStimulus(1'b1, 2'd1, 8'h55, 1'b0);
      checkOutput("reload.load_b", load_b, 1);
      checkOutput("reload.addr_b", addr_b, 0);
      checkOutput("reload.instr_b", instr_b, 0);
      checkOutput("reload.data_b", data_b, 8'h55);
      checkOutput("reload.timeout_b", to_b, 0);
      checkOutput("reload.state_b", state_b, 1);
      checkOutput("reload.icount_a", ic_a, 0);
      applyStimulus(1'b1, 2'd0, 8'h66, 1'b0);
      checkOutput("reload.iaddr_a", addr_a, 0);
      checkOutput("reload.icount2_a", ic_a, 1);

      // Reset while a load pulse is on the outputs
      applyStimulus(1'b1, 2'd0, 8'h77, 1'b0);
      checkOutput("abort_load.pre_load", load_a, 1);
      reset = 1'b1;
      #1;
      checkResetValues("abort_load");
      @(negedge clk);
      cmd_valid = 1'b0;
      reset = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
      checkOutput("abort_load.post_load", load_a, 0);

      // Reset mid-run while a write command is being presented
      applyStimulus(1'b1, 2'd2, 8'h00, 1'b0);
      applyStimulus(1'b1, 2'd0, 8'h88, 1'b0);
      checkOutput("abort_run.err", err_a, 1);
      checkOutput("abort_run.nolad", load_a, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkResetValues("abort_run");
      @(negedge clk);
      cmd_valid = 1'b0;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
         checkOutput($sformatf("abort_run.post%0d.load", k), load_a, 0);
         checkOutput($sformatf("abort_run.post%0d.state", k), state_a, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
